pwm_multi: RTL and testbench

//  Multi-channel PWM generator: one shared period counter drives CHANNELS compare outputs.

---
 rtl/pwm_pkg.sv | 37 +++
 rtl/pwm_channel.sv | 41 ++++
 rtl/pwm_multi.sv | 110 +++++++++++
 tb/tb_pwm_multi.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared encodings and types for the multi-channel PWM generator.
package pwm_pkg;

  // Register select encodings on the write port.
  localparam logic [1:0] SEL_CTRL = 2'b00;
  localparam logic [1:0] SEL_CMP  = 2'b01;
  localparam logic [1:0] SEL_TOP  = 2'b10;
  localparam logic [1:0] SEL_CNT  = 2'b11;

  // CTRL bit positions.
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CENTER = 1;
  localparam int unsigned CTRL_BYPASS = 2;
  localparam int unsigned CTRL_W      = 3;

  // Packed so that field positions line up with the CTRL bit indices above.
  typedef struct packed {
    logic bypass;
    logic center;
    logic en;
  } ctrl_t;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_t;

  // Decode the low CTRL bits of a write word.
  function automatic ctrl_t ctrl_decode(input logic [CTRL_W-1:0] bits);
    ctrl_t c;
    c.en     = bits[CTRL_EN];
    c.center = bits[CTRL_CENTER];
    c.bypass = bits[CTRL_BYPASS];
    return c;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: shadowed compare register plus registered output.
module pwm_channel #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             out_o
);

  logic [WIDTH-1:0] cmp_sh_q, cmp_sh_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             out_q, out_d;

  // Shadow capture, shadow->active transfer (a same-cycle write is included) and compare.
  always_comb begin
    cmp_sh_d = wr_i ? wr_data_i : cmp_sh_q;
    cmp_d    = load_i ? cmp_sh_d : cmp_q;
    out_d    = en_i && (cmp_q != '0) && (cnt_i < cmp_q);
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_sh_q <= '0;
      cmp_q    <= '0;
      out_q    <= 1'b0;
    end else begin
      cmp_sh_q <= cmp_sh_d;
      cmp_q    <= cmp_d;
      out_q    <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/centre-aligned period counter with shadowed TOP and
// per-channel compare outputs. WIDTH must be at least 3 to hold the CTRL bits.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [1:0]          wr_sel_i,
  input  logic [CH_W-1:0]     wr_ch_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  output logic [WIDTH-1:0]    cnt_o,
  output logic [WIDTH-1:0]    top_o,
  output logic [CHANNELS-1:0] out_o,
  output logic                period_end_o
);

  ctrl_t            ctrl_q, ctrl_d;
  dir_t             dir_q, dir_d, dir_run;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_run;
  logic [WIDTH-1:0] top_sh_q, top_sh_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             period_end;
  logic             load;
  logic             wr_ctrl, wr_cmp, wr_top, wr_cnt;

  assign wr_ctrl = wr_en_i && (wr_sel_i == SEL_CTRL);
  assign wr_cmp  = wr_en_i && (wr_sel_i == SEL_CMP);
  assign wr_top  = wr_en_i && (wr_sel_i == SEL_TOP);
  assign wr_cnt  = wr_en_i && (wr_sel_i == SEL_CNT);

  // Free-running count step, ignoring enable and CNT writes.
  always_comb begin
    cnt_run = cnt_q;
    dir_run = dir_q;
    if (!ctrl_q.center) begin
      // >= also catches TOP lowered below the current count.
      cnt_run = (cnt_q >= top_q) ? '0 : cnt_q + WIDTH'(1);
      dir_run = DirUp;
    end else if (dir_q == DirUp && cnt_q < top_q) begin
      cnt_run = cnt_q + WIDTH'(1);
    end else begin
      cnt_run = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
      dir_run = DirDown;
    end
    if (cnt_run == '0) begin
      dir_run = DirUp;
    end
  end

  // Counter update, period boundary detection and shadow->active loads.
  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    period_end = 1'b0;
    if (wr_cnt) begin
      cnt_d = wr_data_i;
      dir_d = DirUp;
    end else if (ctrl_q.en) begin
      cnt_d      = cnt_run;
      dir_d      = dir_run;
      period_end = (cnt_run == '0);
    end
    load     = period_end || !ctrl_q.en || ctrl_q.bypass;
    top_sh_d = wr_top ? wr_data_i : top_sh_q;
    top_d    = load ? top_sh_d : top_q;
    ctrl_d   = wr_ctrl ? ctrl_decode(wr_data_i[CTRL_W-1:0]) : ctrl_q;
  end

  // Shared state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      dir_q    <= DirUp;
      cnt_q    <= '0;
      top_sh_q <= '0;
      top_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      top_sh_q <= top_sh_d;
      top_q    <= top_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_i     (wr_cmp && (wr_ch_i == CH_W'(i))),
      .wr_data_i(wr_data_i),
      .load_i   (load),
      .en_i     (ctrl_q.en),
      .cnt_i    (cnt_q),
      .out_o    (out_o[i])
    );
  end

  assign cnt_o        = cnt_q;
  assign top_o        = top_q;
  assign period_end_o = period_end;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios followed by random register traffic, every cycle
// checked against a behavioural model of the PWM rules.
module tb_pwm_multi;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_sel = 2'b00;
  logic [1:0]    wr_ch = 2'b00;
  logic [15:0]   wr_data = 16'h0;
  logic [15:0]   cnt_o, top_o;
  logic [CH-1:0] out_o;
  logic          period_end_o;

  int tests = 0;
  int fails = 0;

  pwm_multi #(
    .WIDTH   (16),
    .CHANNELS(CH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_sel_i    (wr_sel),
    .wr_ch_i     (wr_ch),
    .wr_data_i   (wr_data),
    .cnt_o       (cnt_o),
    .top_o       (top_o),
    .out_o       (out_o),
    .period_end_o(period_end_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  int m_cnt, m_top, m_tsh;
  bit m_up, m_en, m_ctr, m_byp;
  int m_cmp[CH];
  int m_csh[CH];
  bit m_out[CH];
  // Model's view of the coming edge.
  int e_cnt;
  bit e_up, e_pe;

  task automatic model_reset();
    m_cnt = 0; m_top = 0; m_tsh = 0;
    m_up = 1; m_en = 0; m_ctr = 0; m_byp = 0;
    for (int i = 0; i < CH; i++) begin
      m_cmp[i] = 0; m_csh[i] = 0; m_out[i] = 0;
    end
  endtask

  // Where the counter would go next if it were allowed to count.
  task automatic model_next();
    bit cnt_wr;
    cnt_wr = wr_en && wr_sel == 2'd3;
    if (!m_ctr) begin
      e_up  = 1;
      e_cnt = (m_cnt >= m_top) ? 0 : m_cnt + 1;
    end else if (m_up && m_cnt < m_top) begin
      e_up  = 1;
      e_cnt = m_cnt + 1;
    end else begin
      e_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      e_up  = (e_cnt == 0);
    end
    e_pe = m_en && !cnt_wr && e_cnt == 0;
  endtask

  // Apply one clock edge to the model.
  task automatic model_commit();
    bit load;
    int d;
    d = int'(wr_data);
    for (int i = 0; i < CH; i++) m_out[i] = m_en && m_cmp[i] != 0 && m_cnt < m_cmp[i];
    load = e_pe || !m_en || m_byp;
    if (wr_en && wr_sel == 2'd1) m_csh[wr_ch] = d;
    if (wr_en && wr_sel == 2'd2) m_tsh = d;
    if (load) begin
      m_top = m_tsh;
      for (int i = 0; i < CH; i++) m_cmp[i] = m_csh[i];
    end
    if (wr_en && wr_sel == 2'd3) begin
      m_cnt = d; m_up = 1;
    end else if (m_en) begin
      m_cnt = e_cnt; m_up = e_up;
    end
    if (wr_en && wr_sel == 2'd0) begin
      m_en = d[0]; m_ctr = d[1]; m_byp = d[2];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] model_out();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_out[i];
    return v;
  endfunction

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_next();
    chk("cnt", 32'(cnt_o), m_cnt);
    chk("top", 32'(top_o), m_top);
    chk("out", 32'(out_o), 32'(model_out()));
    chk("period_end", 32'(period_end_o), 32'(e_pe));
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input int sel, input int ch, input int data);
    wr_en   = 1'b1;
    wr_sel  = 2'(sel);
    wr_ch   = 2'(ch);
    wr_data = 16'(data);
    cycle();
    wr_en   = 1'b0;
  endtask

  // Run until the counter shows v, with a cycle budget.
  task automatic wait_cnt(input int v);
    int k = 0;
    while (int'(cnt_o) != v && k < 60) begin
      cycle();
      k++;
    end
    chk("wait_cnt", 32'(cnt_o), v);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(cnt_o), 0);
    chk("rst_top", 32'(top_o), 0);
    chk("rst_out", 32'(out_o), 0);
    chk("rst_pe", 32'(period_end_o), 0);
    rst = 1'b0;
    idle(2);

    // Edge mode, TOP=4, CMP0=2.
    wr(2, 0, 4);
    wr(1, 0, 2);
    wr(0, 0, 1);
    idle(12);

    // Constant-low, constant-high and 4-of-5 channels.
    wr(1, 1, 7);
    wr(1, 2, 4);
    wr(1, 0, 0);
    idle(12);

    // Shadowed compare change mid-period, then the same with bypass.
    wr(2, 0, 9);
    wr(1, 0, 3);
    idle(12);
    wait_cnt(2);
    wr(1, 0, 6);
    idle(22);
    wr(0, 0, 5);
    wait_cnt(2);
    wr(1, 0, 2);
    idle(4);
    wr(0, 0, 1);

    // Centre-aligned, TOP=3, CMP0=2.
    wr(0, 0, 3);
    wr(2, 0, 3);
    idle(12);
    wr(1, 0, 2);
    idle(20);

    // CNT write above TOP, then TOP=0.
    wr(0, 0, 1);
    wr(2, 0, 4);
    idle(8);
    wr(3, 0, 7);
    idle(4);
    wr(2, 0, 0);
    idle(8);

    // Disable mid-period, TOP write while disabled, then asynchronous reset.
    wr(2, 0, 8);
    idle(12);
    wait_cnt(3);
    wr(0, 0, 0);
    idle(3);
    wr(2, 0, 5);
    idle(2);
    wr(0, 0, 1);
    wait_cnt(1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(out_o), 0);
    chk("arst_cnt", 32'(cnt_o), 0);
    chk("arst_top", 32'(top_o), 0);
    chk("arst_pe", 32'(period_end_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Random register traffic with enable mostly on.
    wr(0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 9))
          0:       wr(0, 0, int'($urandom_range(0, 7)) | ($urandom_range(0, 3) != 0 ? 1 : 0));
          1, 2, 3: wr(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
          4, 5, 6: wr(2, 0, int'($urandom_range(0, 10)));
          default: wr(3, 0, int'($urandom_range(0, 12)));
        endcase
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
